time_of_day_counter: RTL and testbench
======================================

// Module: time_of_day_counter
// PURPOSE
//  Hours/minutes/seconds clock core. Upstream stage of the day counter.
//  Divides clk down to a 1 s tick and counts 00:00:00..23:59:59.
//  Emits ClkDay, a one-clk pulse on each midnight rollover, which the day counter consumes.
//  Supports digit-wise edit with KeyPlus/KeyMinus on the time screen (screen==0).
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per second tick; must be >=2. Benches use 4.
// PORTS
//  clk       in   1  system clock; everything is posedge clk
//  reset     in   1  asynchronous, active-low reset
//  KeyPlus   in   1  active-low increment key
//  KeyMinus  in   1  active-low decrement key
//  EditMode  in   1  1 = edit mode: time frozen, keys active
//  EditPos   in   3  digit select: 0=hr tens, 1=hr units, 2=min tens, 3=min units, 4=sec tens, 5=sec units; 6,7 = no digit
//  screen    in   2  active display screen; this block edits only when screen==0
//  hours     out  5  0..23
//  minutes   out  6  0..59
//  seconds   out  6  0..59
//  ClkDay    out  1  registered one-clk pulse on midnight rollover
// BEHAVIOUR
//  Reset (reset==0, async): hours=12, minutes=0, seconds=0, ClkDay=0, prescaler=0, pending edit=none.
//  Prescaler:
//   - While EditMode==0 it counts 0..TICK_DIV-1.
//   - tick = (prescaler==TICK_DIV-1).
//   - While EditMode==1 it is held at 0, so the first tick after leaving edit comes TICK_DIV cycles later.
//  Run (EditMode==0), on tick:
//   - seconds+1; at 59 -> 0 and minutes+1.
//   - minutes at 59 -> 0 and hours+1; hours at 23 -> 0.
//  ClkDay:
//   - Goes to 1 in the same edge that loads 00:00:00 from 23:59:59, so it is visible with the new time.
//   - Returns to 0 on the next edge.
//   - Never asserted while EditMode==1 and never asserted by edits.
//  Edit FSM (pending register):
//   - States: NONE, INC, DEC.
//   - Any cycle with KeyPlus==0 sets pending=INC if edit is valid (EditMode==1, screen==0, EditPos<=5); otherwise it sets pending=NONE.
//   - Else, any cycle with KeyMinus==0 sets pending=DEC under the same rule.
//   - KeyPlus has priority when both keys are low.
//   - Else (both keys high): apply pending to the selected digit, then set pending=NONE.
//   - Net effect: exactly one edit per press, applied on the first clk edge after release.
//   - A key held for any number of cycles still gives one edit.
//   - A press begun in edit mode is discarded if EditMode drops or screen changes before release.
//  Digit arithmetic (u = units digit, t = tens digit of the field):
//   - sec/min units INC: u==9 ? -9 : +1.  DEC: u==0 ? +9 : -1.
//   - sec/min tens INC: >=50 ? -50 : +10.  DEC: <10 ? +50 : -10.
//   - hr units INC: (u==9 || hours==23) ? hours-u : +1.
//   - hr units DEC: u==0 ? (t==2 ? hours+3 : hours+9) : -1.
//   - hr tens INC: >=20 ? -20 : min(hours+10, 23).
//   - hr tens DEC: <10 ? min(hours+20, 23) : -10.
//   - Results are always in range; no other field changes (no carry/borrow between fields).
//  Simultaneity:
//   - Ticks and edits never coincide (ticks run only with EditMode==0; edits apply only with EditMode==1).
//   - Reset mid-press clears pending, so no edit follows reset release.
// TESTING  (TICK_DIV=4)
//  1. Release reset, EditMode=0 -> seconds increments every 4 clks; 1:00 of time -> 12:01:00.
//  2. Load 23:59:58 via edits, EditMode=0 -> after 2 ticks time=00:00:00, ClkDay=1 for exactly 1 clk, then 0.
//  3. EditMode=1, screen=0, EditPos=5, seconds=09, KeyPlus low 10 clks then high -> seconds=00 one clk after release; single change.
//  4. hours=15, EditPos=0: INC -> 23. INC -> 03. DEC -> 23. EditPos=1 at 23: INC -> 20. DEC at 20 -> 23.
//  5. screen=1 (or EditMode=0, or EditPos=6) with KeyMinus pulsed -> no field changes. Press with EditMode dropped before release -> no change.
//  6. Assert reset mid-press and mid-prescale -> outputs 12:00:00, ClkDay=0 immediately; release -> no stray edit; first tick 4 clks later.

Source files
------------

// File: rtl/time_of_day_counter_if.sv
// Key/edit inputs and time outputs of the time-of-day counter.
// The master side drives keys and edit selection; the slave side is the counter.
interface time_of_day_counter_if;
    logic       KeyPlus;
    logic       KeyMinus;
    logic       EditMode;
    logic [2:0] EditPos;
    logic [1:0] screen;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       ClkDay;

    modport master (
        output KeyPlus, KeyMinus, EditMode, EditPos, screen,
        input  hours, minutes, seconds, ClkDay
    );

    modport slave (
        input  KeyPlus, KeyMinus, EditMode, EditPos, screen,
        output hours, minutes, seconds, ClkDay
    );
endinterface

// File: rtl/time_of_day_counter.sv
// Hours/minutes/seconds clock core with a 1 s prescaler, midnight pulse
// and digit-wise key editing on the time screen.
module time_of_day_counter #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    time_of_day_counter_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_INC  = 2'd1,
        PEND_DEC  = 2'd2
    } pend_e;

    pend_e          pend_q, pend_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [4:0]     hours_q, hours_d;
    logic [5:0]     minutes_q, minutes_d;
    logic [5:0]     seconds_q, seconds_d;
    logic           clkday_q, clkday_d;

    logic           tick_c;
    logic           edit_ok_c;
    logic           apply_c;
    logic           apply_inc_c;

    // Minutes/seconds digit edit: wraps within the digit, no carry into the next field.
    function automatic logic [5:0] ms_edit(input logic [5:0] f, input logic units, input logic inc);
        logic [5:0] u;
        logic [5:0] r;
        u = f % 6'd10;
        if (units) begin
            if (inc) r = (u == 6'd9) ? f - 6'd9 : f + 6'd1;
            else     r = (u == 6'd0) ? f + 6'd9 : f - 6'd1;
        end else begin
            if (inc) r = (f >= 6'd50) ? f - 6'd50 : f + 6'd10;
            else     r = (f <  6'd10) ? f + 6'd50 : f - 6'd10;
        end
        return r;
    endfunction

    // Hours digit edit, clamped so the result always stays within 0..23.
    function automatic logic [4:0] hr_edit(input logic [4:0] h, input logic units, input logic inc);
        logic [4:0] u;
        logic [4:0] t;
        logic [4:0] r;
        u = h % 5'd10;
        t = h / 5'd10;
        if (units) begin
            if (inc) r = (u == 5'd9 || h == 5'd23) ? h - u : h + 5'd1;
            else     r = (u == 5'd0) ? ((t == 5'd2) ? h + 5'd3 : h + 5'd9) : h - 5'd1;
        end else begin
            if (inc) r = (h >= 5'd20) ? h - 5'd20 : ((h + 5'd10 > 5'd23) ? 5'd23 : h + 5'd10);
            else     r = (h <  5'd10) ? ((h + 5'd20 > 5'd23) ? 5'd23 : h + 5'd20) : h - 5'd10;
        end
        return r;
    endfunction

    assign tick_c    = !bus.EditMode && (presc_q == PW'(TICK_DIV - 1));
    assign edit_ok_c = bus.EditMode && (bus.screen == 2'd0) && (bus.EditPos <= 3'd5);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= PEND_NONE;
            presc_q   <= '0;
            hours_q   <= 5'd12;
            minutes_q <= 6'd0;
            seconds_q <= 6'd0;
            clkday_q  <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            presc_q   <= presc_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            clkday_q  <= clkday_d;
        end
    end

    // Pending-edit FSM: latch the key while held, apply once on release.
    always_comb begin
        pend_d      = pend_q;
        apply_c     = 1'b0;
        apply_inc_c = 1'b0;
        if (!bus.KeyPlus) begin
            pend_d = edit_ok_c ? PEND_INC : PEND_NONE;
        end else if (!bus.KeyMinus) begin
            pend_d = edit_ok_c ? PEND_DEC : PEND_NONE;
        end else begin
            apply_c     = edit_ok_c && (pend_q != PEND_NONE);
            apply_inc_c = (pend_q == PEND_INC);
            pend_d      = PEND_NONE;
        end
    end

    // Time datapath: tick-driven counting or a single digit edit.
    always_comb begin
        presc_d   = presc_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        clkday_d  = 1'b0;

        if (bus.EditMode || tick_c) presc_d = '0;
        else                        presc_d = presc_q + PW'(1);

        if (tick_c) begin
            if (seconds_q == 6'd59) begin
                seconds_d = 6'd0;
                if (minutes_q == 6'd59) begin
                    minutes_d = 6'd0;
                    if (hours_q == 5'd23) begin
                        hours_d  = 5'd0;
                        clkday_d = 1'b1;
                    end else begin
                        hours_d = hours_q + 5'd1;
                    end
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end else if (apply_c) begin
            case (bus.EditPos)
                3'd0:    hours_d   = hr_edit(hours_q, 1'b0, apply_inc_c);
                3'd1:    hours_d   = hr_edit(hours_q, 1'b1, apply_inc_c);
                3'd2:    minutes_d = ms_edit(minutes_q, 1'b0, apply_inc_c);
                3'd3:    minutes_d = ms_edit(minutes_q, 1'b1, apply_inc_c);
                3'd4:    seconds_d = ms_edit(seconds_q, 1'b0, apply_inc_c);
                3'd5:    seconds_d = ms_edit(seconds_q, 1'b1, apply_inc_c);
                default: ;
            endcase
        end
    end

    assign bus.hours   = hours_q;
    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;
    assign bus.ClkDay  = clkday_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Randomized bench for time_of_day_counter against a seconds-of-day reference model.
module tb_time_of_day_counter;

    localparam int TICK = 4;

    logic       clk;
    logic       rst;
    logic       kp, km, em;
    logic [2:0] pos;
    logic [1:0] scr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: time as seconds since midnight.
    int r_tod, r_phase, r_pend;
    bit r_day;

    time_of_day_counter_if bus ();

    assign bus.KeyPlus  = kp;
    assign bus.KeyMinus = km;
    assign bus.EditMode = em;
    assign bus.EditPos  = pos;
    assign bus.screen   = scr;

    time_of_day_counter #(.TICK_DIV(TICK)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ms_digit(input int f, input bit tens, input int dir);
        int t, u;
        t = f / 10;
        u = f % 10;
        if (tens) t = (t + dir + 6) % 6;
        else      u = (u + dir + 10) % 10;
        return t * 10 + u;
    endfunction

    function automatic int min23(input int v);
        return (v > 23) ? 23 : v;
    endfunction

    function automatic int hr_digit(input int h, input bit tens, input int dir);
        int t, u;
        t = h / 10;
        u = h % 10;
        if (tens) begin
            if (dir > 0) return (t == 2) ? u : min23(h + 10);
            else         return (t == 0) ? min23(h + 20) : h - 10;
        end else begin
            if (dir > 0) return (u == 9 || h == 23) ? t * 10 : h + 1;
            else         return (u == 0) ? ((t == 2) ? 23 : t * 10 + 9) : h - 1;
        end
    endfunction

    task automatic model_reset();
        r_tod   = 12 * 3600;
        r_phase = 0;
        r_pend  = 0;
        r_day   = 1'b0;
    endtask

    task automatic model_edit(input int p, input int dir);
        int h, m, s;
        h = r_tod / 3600;
        m = (r_tod / 60) % 60;
        s = r_tod % 60;
        case (p)
            0: h = hr_digit(h, 1'b1, dir);
            1: h = hr_digit(h, 1'b0, dir);
            2: m = ms_digit(m, 1'b1, dir);
            3: m = ms_digit(m, 1'b0, dir);
            4: s = ms_digit(s, 1'b1, dir);
            5: s = ms_digit(s, 1'b0, dir);
            default: ;
        endcase
        r_tod = h * 3600 + m * 60 + s;
    endtask

    task automatic model_step();
        bit valid, tick;
        if (!rst) begin
            model_reset();
        end else begin
            valid = em && (scr == 0) && (pos <= 5);
            tick  = !em && (r_phase == TICK - 1);
            r_day = 1'b0;
            if (tick) begin
                r_tod = (r_tod + 1) % 86400;
                r_day = (r_tod == 0);
            end
            r_phase = em ? 0 : (r_phase + 1) % TICK;
            if (!kp)      r_pend = valid ? 1 : 0;
            else if (!km) r_pend = valid ? -1 : 0;
            else begin
                if (r_pend != 0 && valid) model_edit(int'(pos), r_pend);
                r_pend = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("hours",   int'(bus.hours),   r_tod / 3600);
        check_eq("minutes", int'(bus.minutes), (r_tod / 60) % 60);
        check_eq("seconds", int'(bus.seconds), r_tod % 60);
        check_eq("clkday",  int'(bus.ClkDay),  int'(r_day));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic press(input bit plus, input int p, input int hold);
        pos = 3'(p);
        if (plus) kp = 1'b0;
        else      km = 1'b0;
        repeat (hold) cyc();
        kp = 1'b1;
        km = 1'b1;
        cyc();
    endtask

    function automatic int dut_tod();
        return int'(bus.hours) * 3600 + int'(bus.minutes) * 60 + int'(bus.seconds);
    endfunction

    int saved;

    initial begin
        rst = 1'b0;
        kp  = 1'b1;
        km  = 1'b1;
        em  = 1'b0;
        pos = 3'd7;
        scr = 2'd0;
        model_reset();
        cyc();
        cyc();
        check_eq("reset_hours", int'(bus.hours), 12);
        check_eq("reset_clkday", int'(bus.ClkDay), 0);
        rst = 1'b1;

        // Free run: one second per TICK clocks.
        repeat (TICK - 1) cyc();
        check_eq("pre_tick_sec", int'(bus.seconds), 0);
        cyc();
        check_eq("first_tick_sec", int'(bus.seconds), 1);
        repeat (60 * TICK - TICK) cyc();
        check_eq("run_1min", dut_tod(), 12 * 3600 + 60);

        // Load 23:59:58 by edits, then roll over midnight.
        em = 1'b1;
        press(1'b1, 0, 2);
        press(1'b1, 1, 1);
        press(1'b0, 2, 1);
        press(1'b0, 3, 1);
        press(1'b0, 3, 1);
        press(1'b0, 4, 1);
        press(1'b0, 5, 1);
        press(1'b0, 5, 1);
        check_eq("loaded", dut_tod(), 23 * 3600 + 59 * 60 + 58);
        em = 1'b0;
        repeat (2 * TICK - 1) cyc();
        check_eq("pre_midnight_day", int'(bus.ClkDay), 0);
        cyc();
        check_eq("midnight_tod", dut_tod(), 0);
        check_eq("midnight_day", int'(bus.ClkDay), 1);
        cyc();
        check_eq("day_pulse_end", int'(bus.ClkDay), 0);

        // Hours digit edits around the 20/23 boundaries.
        em = 1'b1;
        press(1'b1, 0, 1);
        repeat (5) press(1'b1, 1, 1);
        check_eq("hr_15", int'(bus.hours), 15);
        press(1'b1, 0, 1);
        check_eq("hr_tens_inc_clamp", int'(bus.hours), 23);
        press(1'b1, 0, 1);
        check_eq("hr_tens_inc_wrap", int'(bus.hours), 3);
        press(1'b0, 0, 1);
        check_eq("hr_tens_dec_clamp", int'(bus.hours), 23);
        press(1'b1, 1, 1);
        check_eq("hr_units_inc_23", int'(bus.hours), 20);
        press(1'b0, 1, 1);
        check_eq("hr_units_dec_20", int'(bus.hours), 23);

        // Long press on seconds units at 09.
        for (int i = 0; i < 6 && (r_tod % 60) / 10 != 0; i++) press(1'b0, 4, 1);
        for (int i = 0; i < 10 && r_tod % 10 != 9; i++) press(1'b1, 5, 1);
        check_eq("sec_09", int'(bus.seconds), 9);
        pos = 3'd5;
        kp  = 1'b0;
        repeat (10) cyc();
        check_eq("held_no_change", int'(bus.seconds), 9);
        kp = 1'b1;
        cyc();
        check_eq("release_sec", int'(bus.seconds), 0);
        cyc();
        check_eq("single_change", int'(bus.seconds), 0);

        // Presses that must not edit anything.
        saved = r_tod;
        scr = 2'd1;
        press(1'b0, 5, 1);
        scr = 2'd0;
        check_eq("screen1_noedit", dut_tod(), saved);
        press(1'b0, 6, 1);
        check_eq("pos6_noedit", dut_tod(), saved);
        em = 1'b0;
        press(1'b0, 5, 1);
        em = 1'b1;
        cyc();
        check_eq("run_noedit", dut_tod(), saved);
        pos = 3'd5;
        km  = 1'b0;
        cyc();
        cyc();
        em = 1'b0;
        cyc();
        em = 1'b1;
        km = 1'b1;
        cyc();
        check_eq("drop_edit_discard", dut_tod(), saved);

        // Reset mid-press clears pending.
        pos = 3'd5;
        kp  = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_press_tod", dut_tod(), 12 * 3600);
        kp = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        check_eq("no_stray_edit", dut_tod(), 12 * 3600);

        // Reset mid-prescale restarts the tick period.
        em = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        cyc();
        rst = 1'b1;
        repeat (TICK - 1) cyc();
        check_eq("rst_pre_tick", int'(bus.seconds), 0);
        cyc();
        check_eq("rst_first_tick", int'(bus.seconds), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) em = ~em;
            kp  = ($urandom_range(0, 5) != 0);
            km  = ($urandom_range(0, 5) != 0);
            pos = 3'($urandom_range(0, 7));
            scr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
